// File: rtl/ramb4_s8_port_arbiter_if.sv
// Client and RAM port B signal bundle for the RAMB4_S1_S8 port B arbiter.
// The slave modport is the arbiter's view; master is the clients-plus-RAM view.
interface ramb4_s8_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              REQ0;
    logic              WE0;
    logic [ADDR_W-1:0] ADDR0;
    logic [DATA_W-1:0] DI0;
    logic              ACK0;
    logic              VLD0;

    logic              REQ1;
    logic              WE1;
    logic [ADDR_W-1:0] ADDR1;
    logic [DATA_W-1:0] DI1;
    logic              ACK1;
    logic              VLD1;

    logic [DATA_W-1:0] RDATA;

    logic              ENB;
    logic              WEB;
    logic [ADDR_W-1:0] ADDRB;
    logic [DATA_W-1:0] DIB;
    logic              RSTB;
    logic [DATA_W-1:0] DOB;

    modport slave (
        input  REQ0, WE0, ADDR0, DI0,
        input  REQ1, WE1, ADDR1, DI1,
        output ACK0, VLD0, ACK1, VLD1, RDATA,
        output ENB, WEB, ADDRB, DIB, RSTB,
        input  DOB
    );

    modport master (
        output REQ0, WE0, ADDR0, DI0,
        output REQ1, WE1, ADDR1, DI1,
        input  ACK0, VLD0, ACK1, VLD1, RDATA,
        input  ENB, WEB, ADDRB, DIB, RSTB,
        output DOB
    );
endinterface

// File: rtl/ramb4_s8_port_arbiter.sv
// Shares RAMB4_S1_S8 port B between two byte clients with registered RAM-side outputs.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module ramb4_s8_port_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter bit LAST_INIT = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST,
    ramb4_s8_port_arbiter_if.slave bus
);
    logic              elig0;
    logic              elig1;
    logic              grant;
    logic              win;
    logic              we_win;
    logic [ADDR_W-1:0] addr_win;
    logic [DATA_W-1:0] di_win;
    logic              issue0;
    logic              issue1;
    logic              pend0;
    logic              pend1;
`ifndef ARB_FIXED_PRIO_EN
    logic              last;
`endif

    // A requester whose ACK is showing this cycle is already served and sits out.
    always_comb begin
        elig0 = bus.REQ0 & ~bus.ACK0;
        elig1 = bus.REQ1 & ~bus.ACK1;
        grant = elig0 | elig1;
`ifdef ARB_FIXED_PRIO_EN
        win   = ~elig0;
`else
        win   = (elig0 & elig1) ? ~last : elig1;
`endif
        we_win   = win ? bus.WE1   : bus.WE0;
        addr_win = win ? bus.ADDR1 : bus.ADDR0;
        di_win   = win ? bus.DI1   : bus.DI0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.ACK0  <= 1'b0;
            bus.ACK1  <= 1'b0;
            bus.ENB   <= 1'b0;
            bus.WEB   <= 1'b0;
            bus.ADDRB <= '0;
            bus.DIB   <= '0;
            issue0    <= 1'b0;
            issue1    <= 1'b0;
            pend0     <= 1'b0;
            pend1     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last      <= LAST_INIT;
`endif
        end else begin
            bus.ACK0 <= grant & ~win;
            bus.ACK1 <= grant & win;
            bus.ENB  <= grant;
            bus.WEB  <= grant & we_win;
            if (grant) begin
                bus.ADDRB <= addr_win;
                bus.DIB   <= di_win;
            end
            // Reads travel two stages: issued with ACK, data valid when the RAM has sampled.
            issue0 <= grant & ~win & ~we_win;
            issue1 <= grant & win & ~we_win;
            pend0  <= issue0;
            pend1  <= issue1;
`ifndef ARB_FIXED_PRIO_EN
            if (elig0 & elig1) begin
                last <= win;
            end
`endif
        end
    end

    // Gating with RST drops a read whose data would land in the reset cycle.
    assign bus.VLD0  = pend0 & ~RST;
    assign bus.VLD1  = pend1 & ~RST;
    assign bus.RDATA = bus.DOB;
    assign bus.RSTB  = 1'b0;
endmodule

// File: tb/tb_ramb4_s8_port_arbiter.sv
// Bench for ramb4_s8_port_arbiter: directed scenarios then random traffic checked
// against a transaction-level model with a shadow memory.
module tb_ramb4_s8_port_arbiter;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    ramb4_s8_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ramb4_s8_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LAST_INIT(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] initVal(input int i);
        if (i == 0)   return 8'h11;
        if (i == 511) return 8'h22;
        return 8'(i * 37 + 90);
    endfunction

    // Behavioural port B of the block RAM: synchronous, write-through on writes.
    logic [7:0] ram [512];
    logic       loaded = 1'b0;
    always @(posedge CLK) begin
        if (!loaded) begin
            for (int i = 0; i < 512; i++) ram[i] <= initVal(i);
            loaded <= 1'b1;
        end else if (bus.ENB) begin
            if (bus.WEB) begin
                ram[bus.ADDRB] <= bus.DIB;
                bus.DOB        <= bus.DIB;
            end else begin
                bus.DOB <= ram[bus.ADDRB];
            end
        end
    end

    // Model state: what the outputs should show in the current cycle.
    logic [7:0] shadow [512];
    bit         mAck [2];
    bit         mEnb;
    bit         mWeb;
    logic [8:0] mAddrb;
    logic [7:0] mDib;
    int         lastContestWinner;
    bit         s1V, s1Who, s2V, s2Who;
    logic [7:0] s1Data, s2Data;

    logic       obsAck0, obsAck1, obsVld0, obsVld1, obsEnb, obsWeb;
    logic [8:0] obsAddrb;
    logic [7:0] obsDib, obsRdata;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mAck[0] = 0;
        mAck[1] = 0;
        mEnb = 0;
        mWeb = 0;
        mAddrb = '0;
        mDib = '0;
        lastContestWinner = 1;
        s1V = 0;
        s2V = 0;
        s1Who = 0;
        s2Who = 0;
        s1Data = '0;
        s2Data = '0;
    endtask

    // Drives one cycle of inputs, checks the cycle's outputs, advances the model.
    task automatic applyStimulus(input logic rst,
                                 input logic r0, input logic we0, input logic [8:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic we1, input logic [8:0] a1, input logic [7:0] d1);
        bit         req [2];
        bit         wv [2];
        logic [8:0] av [2];
        logic [7:0] dv [2];
        bit         nAck [2];
        bit         nEnb, nWeb, nS1V, nS1Who;
        logic [8:0] nAddrb;
        logic [7:0] nDib, nS1Data;
        int         win;
        req[0] = r0; wv[0] = we0; av[0] = a0; dv[0] = d0;
        req[1] = r1; wv[1] = we1; av[1] = a1; dv[1] = d1;
        RST = rst;
        bus.REQ0 = r0; bus.WE0 = we0; bus.ADDR0 = a0; bus.DI0 = d0;
        bus.REQ1 = r1; bus.WE1 = we1; bus.ADDR1 = a1; bus.DI1 = d1;

        @(negedge CLK);
        obsAck0 = bus.ACK0; obsAck1 = bus.ACK1; obsVld0 = bus.VLD0; obsVld1 = bus.VLD1;
        obsEnb = bus.ENB; obsWeb = bus.WEB; obsAddrb = bus.ADDRB; obsDib = bus.DIB;
        obsRdata = bus.RDATA;
        checkOutput("ack0", 32'(obsAck0), 32'(mAck[0]));
        checkOutput("ack1", 32'(obsAck1), 32'(mAck[1]));
        checkOutput("enb", 32'(obsEnb), 32'(mEnb));
        checkOutput("web", 32'(obsWeb), 32'(mWeb));
        checkOutput("addrb", 32'(obsAddrb), 32'(mAddrb));
        checkOutput("dib", 32'(obsDib), 32'(mDib));
        checkOutput("rstb", 32'(bus.RSTB), 32'd0);
        checkOutput("vld0", 32'(obsVld0), 32'(s2V && !s2Who && !rst));
        checkOutput("vld1", 32'(obsVld1), 32'(s2V && s2Who && !rst));
        if (s2V && !rst) checkOutput("rdata", 32'(obsRdata), 32'(s2Data));

        nAck[0] = 0; nAck[1] = 0;
        nEnb = 0; nWeb = 0; nAddrb = mAddrb; nDib = mDib;
        nS1V = 0; nS1Who = 0; nS1Data = '0;
        win = -1;
        if (!rst) begin
            if (req[0] && !mAck[0] && req[1] && !mAck[1]) begin
`ifdef ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = 1 - lastContestWinner;
                lastContestWinner = win;
`endif
            end else if (req[0] && !mAck[0]) begin
                win = 0;
            end else if (req[1] && !mAck[1]) begin
                win = 1;
            end
            if (win >= 0) begin
                nAck[win] = 1;
                nEnb = 1;
                nWeb = wv[win];
                nAddrb = av[win];
                nDib = dv[win];
                if (wv[win]) begin
                    shadow[av[win]] = dv[win];
                end else begin
                    nS1V = 1;
                    nS1Who = (win == 1);
                    nS1Data = shadow[av[win]];
                end
            end
        end

        @(posedge CLK);
        #1;
        if (rst) begin
            modelReset();
        end else begin
            mAck = nAck; mEnb = nEnb; mWeb = nWeb; mAddrb = nAddrb; mDib = nDib;
            s2V = s1V; s2Who = s1Who; s2Data = s1Data;
            s1V = nS1V; s1Who = nS1Who; s1Data = nS1Data;
        end
    endtask

    task automatic idleCycle(input logic rst);
        applyStimulus(rst, 0, 0, 9'h0, 8'h0, 0, 0, 9'h0, 8'h0);
    endtask

    bit         act [2];
    bit         rwe [2];
    logic [8:0] rad [2];
    logic [7:0] rdi [2];
    bit         rrst;

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = initVal(i);
        RST = 1'b1;
        bus.REQ0 = 0; bus.WE0 = 0; bus.ADDR0 = '0; bus.DI0 = '0;
        bus.REQ1 = 0; bus.WE1 = 0; bus.ADDR1 = '0; bus.DI1 = '0;
        repeat (2) @(posedge CLK);
        #1;
        modelReset();
        idleCycle(1);
        idleCycle(0);

        // Write A5 to 005 from requester 0.
        applyStimulus(0, 1, 1, 9'h005, 8'hA5, 0, 0, 9'h0, 8'h0);
        applyStimulus(0, 1, 1, 9'h005, 8'hA5, 0, 0, 9'h0, 8'h0);
        checkOutput("t1_ack0", 32'(obsAck0), 32'd1);
        checkOutput("t1_web", 32'(obsWeb), 32'd1);
        checkOutput("t1_addrb", 32'(obsAddrb), 32'h005);
        checkOutput("t1_dib", 32'(obsDib), 32'hA5);

        // Read it back from requester 1.
        applyStimulus(0, 0, 0, 9'h0, 8'h0, 1, 0, 9'h005, 8'h0);
        checkOutput("t1_novld0", 32'(obsVld0), 32'd0);
        applyStimulus(0, 0, 0, 9'h0, 8'h0, 1, 0, 9'h005, 8'h0);
        checkOutput("t2_ack1", 32'(obsAck1), 32'd1);
        idleCycle(0);
        checkOutput("t2_vld1", 32'(obsVld1), 32'd1);
        checkOutput("t2_rdata", 32'(obsRdata), 32'hA5);
        idleCycle(0);

        // Both requesters streaming reads.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 9'h010, 8'h0, 1, 0, 9'h011, 8'h0);
            if (i > 0) begin
                checkOutput("t3_onehot", 32'(obsAck0) + 32'(obsAck1), 32'd1);
                checkOutput("t3_enb", 32'(obsEnb), 32'd1);
            end
        end
        repeat (3) idleCycle(0);

        // Back-to-back reads of the two ends of the address space.
        applyStimulus(0, 1, 0, 9'h000, 8'h0, 0, 0, 9'h0, 8'h0);
        applyStimulus(0, 1, 0, 9'h000, 8'h0, 0, 0, 9'h0, 8'h0);
        applyStimulus(0, 1, 0, 9'h1FF, 8'h0, 0, 0, 9'h0, 8'h0);
        checkOutput("t4_vld0_a", 32'(obsVld0), 32'd1);
        checkOutput("t4_rdata_a", 32'(obsRdata), 32'h11);
        applyStimulus(0, 1, 0, 9'h1FF, 8'h0, 0, 0, 9'h0, 8'h0);
        idleCycle(0);
        checkOutput("t4_vld0_b", 32'(obsVld0), 32'd1);
        checkOutput("t4_rdata_b", 32'(obsRdata), 32'h22);
        idleCycle(0);

        // Reset lands while a read is in flight.
        applyStimulus(0, 1, 0, 9'h003, 8'h0, 0, 0, 9'h0, 8'h0);
        applyStimulus(0, 1, 0, 9'h003, 8'h0, 0, 0, 9'h0, 8'h0);
        idleCycle(1);
        checkOutput("t5_vld0_rst", 32'(obsVld0), 32'd0);
        idleCycle(0);
        checkOutput("t5_enb", 32'(obsEnb), 32'd0);
        checkOutput("t5_ack0", 32'(obsAck0), 32'd0);
        checkOutput("t5_ack1", 32'(obsAck1), 32'd0);
        checkOutput("t5_vld0", 32'(obsVld0), 32'd0);

        // Requester 1 withdraws before being served.
        applyStimulus(0, 1, 1, 9'h020, 8'h3C, 1, 0, 9'h0AB, 8'h0);
        applyStimulus(0, 1, 1, 9'h020, 8'h3C, 0, 0, 9'h0AB, 8'h0);
        checkOutput("t6_ack0", 32'(obsAck0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idleCycle(0);
            checkOutput("t6_noack1", 32'(obsAck1), 32'd0);
            checkOutput("t6_noaddr1", 32'(obsAddrb == 9'h0AB), 32'd0);
        end

        // Random traffic with holds, withdrawals and occasional resets.
        act[0] = 0; act[1] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rrst = ($urandom_range(0, 199) == 0);
            for (int r = 0; r < 2; r++) begin
                if (rrst) begin
                    act[r] = 0;
                end else if (!act[r] || mAck[r]) begin
                    act[r] = ($urandom_range(0, 99) < 60);
                    rwe[r] = 1'($urandom_range(0, 1));
                    rad[r] = ($urandom_range(0, 9) == 0) ? 9'h1FF : 9'($urandom_range(0, 7));
                    rdi[r] = 8'($urandom);
                end else if ($urandom_range(0, 99) < 5) begin
                    act[r] = 0;
                end
            end
            applyStimulus(rrst, act[0], rwe[0], rad[0], rdi[0], act[1], rwe[1], rad[1], rdi[1]);
        end
        repeat (3) idleCycle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
